memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline stage directly downstream of execute. Holds the EX/MEM pipeline register, performs loads and stores against the data memory through a req/gnt/rvalid handshake, and stalls upstream stages while an access is outstanding. Non-memory instructions pass through with one register of latency. The stage forwards a completed `inst_decoded_t` to writeback.

## Interface
- No parameters. Widths come from `constants_pkg` (`ARCH_LEN` = 32).
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `inst_mem_in`  in  `inst_decoded_t`  from execute. Uses fields `valid`, `is_l`, `is_s`, `func3`, `dst_reg_data` (effective address), `src_data_2` (store data).
- `inst_mem_out`  out  `inst_decoded_t`  to writeback.
- `stall_mem_out`  out  1  upstream must hold `inst_mem_in` stable while this is 1.
- `misaligned_out`  out  1  one-cycle pulse when an access is suppressed.
- `dmem_req_out`  out  1  request valid.
- `dmem_we_out`  out  1  1 = store.
- `dmem_addr_out`  out  `ARCH_LEN`  word-aligned address `{addr[31:2],2'b00}`.
- `dmem_be_out`  out  4  byte enables.
- `dmem_wdata_out`  out  `ARCH_LEN`  lane-replicated store data.
- `dmem_gnt_in`  in  1  request accepted.
- `dmem_rvalid_in`  in  1  load data valid.
- `dmem_rdata_in`  in  `ARCH_LEN`  load data word.

## Operation
- **Input register `inst_q`:** loads `inst_mem_in` on every rising edge where `stall_mem_out` = 0.
- **Memory op:** an instruction with `inst_q.valid & (is_l | is_s)`.
- **FSM states:** IDLE, REQ, WAIT.
  - IDLE: entered after reset. Transitions to REQ on the same edge that loads an aligned memory op into `inst_q`.
  - REQ: `dmem_req_out` = 1 and `addr`/`be`/`we`/`wdata` are driven from `inst_q`.
    - Store: on `gnt`, complete and go to IDLE.
    - Load: on `gnt` without `rvalid`, go to WAIT. On `gnt & rvalid` in the same cycle, complete directly.
  - WAIT: `dmem_req_out` = 0. On `rvalid`, complete.
  - A completion that coincides with a new memory op being loaded goes to REQ instead of IDLE.
- **`stall_mem_out`:** 1 while the FSM is in REQ or WAIT and the access is not completing this cycle. It is 0 in the completion cycle, so the next instruction loads on that edge.
- **`inst_mem_out` default:** equals `inst_q`.
  - `valid` is forced to 0 while stalled, so a bubble goes to writeback.
  - Non-memory op: passed through unchanged.
  - Store completion: `valid` = 1, `reg_data_ready` = 0.
  - Load completion: `dst_reg_data` = extended load data, `reg_data_ready` = 1, `valid` = 1.
- **Byte lanes (`a` = `addr[1:0]`):**
  - SB: `be` = `0001 << a`, `wdata` = byte replicated ×4.
  - SH: `be` = `0011 << a`, `wdata` = half replicated ×2.
  - SW: `be` = `1111`.
- **Load extension:** `func3` 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW takes the full word. The selected lane is chosen by `a`.
- **Misaligned access** (half with `a[0]`=1, or word with `a`≠0):
  - No request is issued and the FSM stays in IDLE.
  - `misaligned_out` = 1 for that cycle, `inst_mem_out.valid` = 0, `stall_mem_out` = 0.
- Any other `func3` on a memory op is treated as a word access.
- **Ignored handshake inputs:** `dmem_rvalid_in` in IDLE/REQ for stores, and `dmem_gnt_in` outside REQ.

## Timing
- **Reset values:** `inst_q.valid` = 0, state = IDLE, all outputs 0 (`inst_mem_out` all-zero).
- **Reset mid-operation:** immediate return to IDLE, `req` drops asynchronously, and a later stray `rvalid` is ignored.
- **Latency:**
  - Non-memory op: 1 cycle (visible the cycle after capture).
  - Store: 1 + N cycles, where N is the number of REQ cycles until `gnt` (≥1).
  - Load: 1 + N + M cycles, where M is the number of WAIT cycles until `rvalid` (0 if `rvalid` arrives with `gnt`).
- **Request rule:** the request stays asserted, with stable address/data/`be`, until `gnt`. The memory must not assert `rvalid` before `gnt`.
- **Throughput:** back-to-back memory ops with `gnt`/`rvalid` always high sustain 1 instruction/cycle, with REQ→REQ transitions.

## Structure
- `structure_pkg`: add `mem_state_t` enum {IDLE, REQ, WAIT}.
- `constants_pkg`: load/store `func3` encodings (`F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101).
- Sub-module `lsu_align` (combinational): `addr[1:0]` + `func3` + store data + read data → `be`, `wdata`, extended load data, misaligned flag.

## Test plan
- **ADD pass-through:** ADD with `dst_reg_data`=0x0000_0042, valid → `inst_mem_out` is identical one cycle later, no `req`, stall 0.
- **SB with 2-cycle grant:** SB to 0x1003, data 0xAB, `gnt` after 2 cycles → `req` held 2 cycles, `addr`=0x1000, `be`=1000, `wdata`=0xABABABAB, stall 1 then 0, output `valid`=1 and `reg_data_ready`=0 on the `gnt` cycle.
- **LB/LBU byte extension:** LB from 0x2002 with `rdata`=0x0080_0000, `gnt` then `rvalid` 3 cycles later → `dst_reg_data`=0xFFFF_FF80. LBU on the same access → 0x0000_0080.
- **LW back-to-back:** LW to 0x3000 then LH to 0x3006, `gnt`=`rvalid`=1 every cycle → two completions on consecutive cycles. LH with `rdata`=0x1234_5678 → 0x0000_1234.
- **Misaligned LW:** LW to 0x4001 → no `req`, `misaligned_out` pulses 1 cycle, output `valid`=0, next instruction accepted the following cycle.
- **Reset during WAIT:** `rst`=0 while in WAIT → `req`/`stall`/`valid` = 0 immediately. After reset release, an `rvalid`=1 pulse produces no output.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types, widths and load/store helpers for the memory stage
//   ARCH_LEN       datapath width
//   F3_*           load/store func3 size encodings
//   mem_state_t    memory access FSM states
//   inst_decoded_t instruction record passed between pipeline stages
package memory_stage_pkg;

    localparam int ARCH_LEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

    typedef struct packed {
        logic                valid;
        logic                is_l;
        logic                is_s;
        logic                reg_data_ready;
        logic [2:0]          func3;
        logic [4:0]          rd;
        logic [ARCH_LEN-1:0] src_data_1;
        logic [ARCH_LEN-1:0] src_data_2;
        logic [ARCH_LEN-1:0] dst_reg_data;
    } inst_decoded_t;

    function automatic logic is_byte(input logic [2:0] f3);
        return f3 == F3_B || f3 == F3_BU;
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return f3 == F3_H || f3 == F3_HU;
    endfunction

    // Unknown func3 values fall through to the word rules.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return is_byte(f3) ? 1'b0 : is_half(f3) ? a[0] : a != 2'b00;
    endfunction

endpackage

// File: rtl/memory_stage_lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction/extension for loads
//   addr/func3         low address bits and access size
//   store_data         register value to store
//   read_data          word returned by memory
//   be/wdata           byte enables and lane-replicated store data
//   load_data          extended load result
//   misaligned         access crosses its natural alignment
module lsu_align
    import memory_stage_pkg::*;
(
    input  logic [1:0]          addr,
    input  logic [2:0]          func3,
    input  logic [ARCH_LEN-1:0] store_data,
    input  logic [ARCH_LEN-1:0] read_data,
    output logic [3:0]          be,
    output logic [ARCH_LEN-1:0] wdata,
    output logic [ARCH_LEN-1:0] load_data,
    output logic                misaligned
);

    logic [ARCH_LEN-1:0] lane;

    always_comb begin
        lane       = read_data >> {addr, 3'b000};
        be         = is_byte(func3) ? 4'b0001 << addr : is_half(func3) ? 4'b0011 << addr : 4'b1111;
        wdata      = is_byte(func3) ? {4{store_data[7:0]}} : is_half(func3) ? {2{store_data[15:0]}} : store_data;
        load_data  = func3 == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                     func3 == F3_BU ? {24'h0, lane[7:0]} :
                     func3 == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                     func3 == F3_HU ? {16'h0, lane[15:0]} : read_data;
        misaligned = is_misaligned(func3, addr);
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register plus load/store unit on a req/gnt/rvalid data memory port
//   clk, rst               clock, asynchronous active-low reset
//   inst_mem_in            instruction from execute (held by upstream while stall_mem_out)
//   inst_mem_out           instruction to writeback (valid=0 is a bubble)
//   stall_mem_out          access outstanding and not completing this cycle
//   misaligned_out         pulse when a misaligned access is dropped
//   dmem_*                 data memory request/response handshake
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  inst_decoded_t       inst_mem_in,
    output inst_decoded_t       inst_mem_out,
    output logic                stall_mem_out,
    output logic                misaligned_out,
    output logic                dmem_req_out,
    output logic                dmem_we_out,
    output logic [ARCH_LEN-1:0] dmem_addr_out,
    output logic [3:0]          dmem_be_out,
    output logic [ARCH_LEN-1:0] dmem_wdata_out,
    input  logic                dmem_gnt_in,
    input  logic                dmem_rvalid_in,
    input  logic [ARCH_LEN-1:0] dmem_rdata_in
);

    inst_decoded_t       inst_q;
    mem_state_t          state;
    logic [3:0]          be;
    logic [ARCH_LEN-1:0] wdata;
    logic [ARCH_LEN-1:0] load_data;
    logic                mis_q;
    logic                done;
    logic                new_op;

    lsu_align u_align (
        .addr       (inst_q.dst_reg_data[1:0]),
        .func3      (inst_q.func3),
        .store_data (inst_q.src_data_2),
        .read_data  (dmem_rdata_in),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .misaligned (mis_q)
    );

    always_comb begin
        dmem_req_out          = state == REQ;
        // Stores finish on grant; loads finish on rvalid, either with the grant or later in WAIT.
        done                  = (dmem_req_out && dmem_gnt_in && (inst_q.is_s || dmem_rvalid_in)) ||
                                (state == WAIT && dmem_rvalid_in);
        stall_mem_out         = state != IDLE && !done;
        // Only aligned memory ops start an access; misaligned ones are reported once captured.
        new_op                = !stall_mem_out && inst_mem_in.valid && (inst_mem_in.is_l || inst_mem_in.is_s) &&
                                !is_misaligned(inst_mem_in.func3, inst_mem_in.dst_reg_data[1:0]);
        misaligned_out        = state == IDLE && inst_q.valid && (inst_q.is_l || inst_q.is_s) && mis_q;
        dmem_we_out           = dmem_req_out && inst_q.is_s;
        dmem_addr_out         = dmem_req_out ? {inst_q.dst_reg_data[ARCH_LEN-1:2], 2'b00} : '0;
        dmem_be_out           = dmem_req_out ? be : 4'b0000;
        dmem_wdata_out        = dmem_req_out ? wdata : '0;
        inst_mem_out          = inst_q;
        inst_mem_out.valid    = inst_q.valid && !stall_mem_out && !misaligned_out;
        inst_mem_out.reg_data_ready = done ? !inst_q.is_s : inst_q.reg_data_ready;
        inst_mem_out.dst_reg_data   = done && !inst_q.is_s ? load_data : inst_q.dst_reg_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            inst_q <= '0;
        end else begin
            if (!stall_mem_out)
                inst_q <= inst_mem_in;
            state <= (state == IDLE || done) ? (new_op ? REQ : IDLE) :
                     (dmem_req_out && dmem_gnt_in) ? WAIT : state;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scoreboard bench for memory_stage
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    inst_decoded_t inst_in = '0;
    inst_decoded_t inst_out;
    logic          stall, mis, req, we, gnt = 1'b0, rvalid = 1'b0;
    logic [31:0]   addr, wdata, rdata = '0;
    logic [3:0]    be;

    int            n_cmp = 0;
    int            n_bad = 0;
    inst_decoded_t exp_q[$];
    inst_decoded_t e;

    memory_stage dut (
        .clk            (clk),
        .rst            (rst),
        .inst_mem_in    (inst_in),
        .inst_mem_out   (inst_out),
        .stall_mem_out  (stall),
        .misaligned_out (mis),
        .dmem_req_out   (req),
        .dmem_we_out    (we),
        .dmem_addr_out  (addr),
        .dmem_be_out    (be),
        .dmem_wdata_out (wdata),
        .dmem_gnt_in    (gnt),
        .dmem_rvalid_in (rvalid),
        .dmem_rdata_in  (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic inst_decoded_t mk(logic l, logic s, logic [2:0] f3, logic [31:0] a, logic [31:0] d, logic [4:0] rd);
        inst_decoded_t i = '0;
        i.valid        = 1'b1;
        i.is_l         = l;
        i.is_s         = s;
        i.func3        = f3;
        i.rd           = rd;
        i.src_data_1   = 32'h1111_0000 | 32'(rd);
        i.src_data_2   = d;
        i.dst_reg_data = a;
        return i;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input string tag);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: got empty scoreboard want pending entry", tag);
        end else begin
            e = exp_q.pop_front();
            assert (inst_out === e) else begin
                n_bad++;
                $error("FAIL %s: got %h want %h", tag, inst_out, e);
            end
        end
    endtask

    initial begin
        inst_decoded_t add1, add2, sb, lb, lbu, lw, lh, lwm, lwr;
        add1 = mk(0, 0, 3'b000, 32'h0000_0042, 32'h5, 5'd5);
        add2 = mk(0, 0, 3'b000, 32'h0000_0077, 32'h6, 5'd6);
        sb   = mk(0, 1, F3_B, 32'h0000_1003, 32'h0000_00AB, 5'd0);
        sb.reg_data_ready = 1'b1;
        lb   = mk(1, 0, F3_B, 32'h0000_2002, 32'h0, 5'd7);
        lbu  = mk(1, 0, F3_BU, 32'h0000_2002, 32'h0, 5'd8);
        lw   = mk(1, 0, F3_W, 32'h0000_3000, 32'h0, 5'd9);
        lh   = mk(1, 0, F3_H, 32'h0000_3006, 32'h0, 5'd10);
        lwm  = mk(1, 0, F3_W, 32'h0000_4001, 32'h0, 5'd11);
        lwr  = mk(1, 0, F3_W, 32'h0000_5000, 32'h0, 5'd12);

        // reset state
        #2;
        chk("rst_out", 32'(inst_out != '0), 0);
        chk("rst_req", req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mis", mis, 0);
        tick();
        tick();
        rst = 1'b1;

        // ADD pass-through
        inst_in = add1;
        exp_q.push_back(add1);
        tick();
        inst_in = '0;
        #1;
        pop_chk("add_out");
        chk("add_req", req, 0);
        chk("add_stall", stall, 0);

        // SB with grant in the second request cycle
        inst_in = sb;
        e = sb;
        e.reg_data_ready = 1'b0;
        exp_q.push_back(e);
        tick();
        #1;
        chk("sb_req1", req, 1);
        chk("sb_we", we, 1);
        chk("sb_addr", addr, 32'h0000_1000);
        chk("sb_be", 32'(be), 32'b1000);
        chk("sb_wdata", wdata, 32'hABAB_ABAB);
        chk("sb_stall1", stall, 1);
        chk("sb_bubble", inst_out.valid, 0);
        tick();
        gnt = 1'b1;
        inst_in = '0;
        #1;
        chk("sb_req2", req, 1);
        chk("sb_addr2", addr, 32'h0000_1000);
        chk("sb_stall2", stall, 0);
        pop_chk("sb_out");
        tick();
        gnt = 1'b0;
        #1;
        chk("sb_req_off", req, 0);
        chk("sb_after", inst_out.valid, 0);

        // LB: grant immediately, rvalid on third WAIT cycle
        inst_in = lb;
        e = lb;
        e.dst_reg_data = 32'hFFFF_FF80;
        e.reg_data_ready = 1'b1;
        exp_q.push_back(e);
        tick();
        gnt = 1'b1;
        #1;
        chk("lb_req", req, 1);
        chk("lb_we", we, 0);
        chk("lb_be", 32'(be), 32'b0100);
        chk("lb_addr", addr, 32'h0000_2000);
        chk("lb_stall_req", stall, 1);
        tick();
        gnt = 1'b0;
        #1;
        chk("lb_wait_req", req, 0);
        chk("lb_wait_stall", stall, 1);
        chk("lb_wait_valid", inst_out.valid, 0);
        tick();
        #1;
        chk("lb_wait2_stall", stall, 1);
        tick();
        rvalid = 1'b1;
        rdata = 32'h0080_0000;
        inst_in = lbu;
        #1;
        chk("lb_done_stall", stall, 0);
        pop_chk("lb_out");

        // LBU of the same location, grant and rvalid together
        e = lbu;
        e.dst_reg_data = 32'h0000_0080;
        e.reg_data_ready = 1'b1;
        exp_q.push_back(e);
        tick();
        rvalid = 1'b0;
        gnt = 1'b1;
        inst_in = '0;
        #1;
        chk("lbu_req", req, 1);
        chk("lbu_stall_hold", stall, 1);
        rvalid = 1'b1;
        #1;
        chk("lbu_stall", stall, 0);
        pop_chk("lbu_out");
        tick();
        gnt = 1'b0;
        rvalid = 1'b0;

        // LW then LH back to back with gnt/rvalid always high
        inst_in = lw;
        e = lw;
        e.dst_reg_data = 32'hDEAD_BEEF;
        e.reg_data_ready = 1'b1;
        exp_q.push_back(e);
        tick();
        gnt = 1'b1;
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        inst_in = lh;
        e = lh;
        e.dst_reg_data = 32'h0000_1234;
        e.reg_data_ready = 1'b1;
        exp_q.push_back(e);
        #1;
        chk("lw_addr", addr, 32'h0000_3000);
        chk("lw_be", 32'(be), 32'b1111);
        chk("lw_stall", stall, 0);
        pop_chk("lw_out");
        tick();
        rdata = 32'h1234_5678;
        inst_in = '0;
        #1;
        chk("lh_req", req, 1);
        chk("lh_addr", addr, 32'h0000_3004);
        chk("lh_be", 32'(be), 32'b1100);
        pop_chk("lh_out");
        tick();
        gnt = 1'b0;
        rvalid = 1'b0;
        #1;
        chk("lh_req_off", req, 0);

        // misaligned LW, then an ADD accepted right after
        inst_in = lwm;
        tick();
        inst_in = add2;
        exp_q.push_back(add2);
        #1;
        chk("mis_pulse", mis, 1);
        chk("mis_req", req, 0);
        chk("mis_stall", stall, 0);
        chk("mis_valid", inst_out.valid, 0);
        tick();
        inst_in = '0;
        #1;
        chk("mis_end", mis, 0);
        pop_chk("mis_next");

        // reset while in WAIT, then stray rvalid
        inst_in = lwr;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #1;
        chk("rw_wait_stall", stall, 1);
        #1;
        rst = 1'b0;
        inst_in = '0;
        #1;
        chk("rw_req", req, 0);
        chk("rw_stall", stall, 0);
        chk("rw_valid", inst_out.valid, 0);
        tick();
        rst = 1'b1;
        tick();
        rvalid = 1'b1;
        rdata = 32'hCAFE_F00D;
        #1;
        chk("rw_stray_valid", inst_out.valid, 0);
        chk("rw_stray_stall", stall, 0);
        tick();
        rvalid = 1'b0;
        #1;
        chk("rw_after_valid", inst_out.valid, 0);
        chk("rw_after_req", req, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
